// File: rtl/dragon_body_reader.sv
// dragon_body_reader: snapshots the packed dragon body vector and tail pointer
// on start, then presents one segment per valid/ready handshake, head first,
// ending with a one-cycle done pulse.
// Optional build macro DRAGON_SELF_COLLIDE_EN adds collide / collide_index,
// which flag any transferred non-head segment sitting on the head's tile.
module dragon_body_reader #(
    parameter int SEG_W    = 12,
    parameter int MAX_SEGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SEG_W*MAX_SEGS-1:0] dragon_body,
    input  logic [IDX_W-1:0]          tail_ptr,
    output logic                      seg_valid,
    input  logic                      seg_ready,
    output logic [IDX_W-1:0]          seg_index,
    output logic [3:0]                seg_orient,
    output logic [3:0]                seg_x,
    output logic [3:0]                seg_y,
    output logic                      seg_last,
    output logic                      busy,
    output logic                      done
`ifdef DRAGON_SELF_COLLIDE_EN
    ,
    output logic                      collide,
    output logic [IDX_W-1:0]          collide_index
`endif
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                      state_reg, state_next;
    logic [SEG_W*MAX_SEGS-1:0]   body_reg;
    logic [IDX_W-1:0]            tail_reg;
    logic                        seg_valid_reg, seg_valid_next;
    logic [IDX_W-1:0]            index_reg, index_next;
    logic [SEG_W-1:0]            seg_reg, seg_next;
    logic                        last_reg, last_next;
    logic                        busy_reg, busy_next;
    logic                        done_reg, done_next;

    logic [SEG_W-1:0]            snap_seg [MAX_SEGS];
    logic [IDX_W-1:0]            index_inc;
    logic                        accept;
    logic                        transfer;
    logic                        at_tail;

    // Unpack the snapshot into per-segment words for indexed lookup
    generate
        for (genvar gi = 0; gi < MAX_SEGS; gi++) begin : g_unpack
            assign snap_seg[gi] = body_reg[gi*SEG_W +: SEG_W];
        end
    endgenerate

    assign accept    = (state_reg == IDLE) && start;
    assign transfer  = (state_reg == STREAM) && seg_valid_reg && seg_ready;
    assign at_tail   = (index_reg == tail_reg);
    assign index_inc = index_reg + 1'b1;

    // State, snapshot and registered output storage
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            body_reg      <= '0;
            tail_reg      <= '0;
            seg_valid_reg <= 1'b0;
            index_reg     <= '0;
            seg_reg       <= '0;
            last_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seg_valid_reg <= seg_valid_next;
            index_reg     <= index_next;
            seg_reg       <= seg_next;
            last_reg      <= last_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            if (accept) begin
                body_reg <= dragon_body;
                tail_reg <= tail_ptr;
            end
        end
    end

    // Next-state: IDLE -> STREAM on start, STREAM -> DONE after tail transfer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (transfer && at_tail) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output next values: load head on accept, advance or finish on transfer,
    // hold everything while the consumer stalls
    always_comb begin
        seg_valid_next = seg_valid_reg;
        index_next     = index_reg;
        seg_next       = seg_reg;
        last_next      = last_reg;
        done_next      = 1'b0;
        busy_next      = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Snapshot is not loaded yet, so take the head from the input
                    seg_valid_next = 1'b1;
                    index_next     = '0;
                    seg_next       = dragon_body[SEG_W-1:0];
                    last_next      = (tail_ptr == '0);
                end
            end
            STREAM: begin
                if (transfer) begin
                    if (at_tail) begin
                        seg_valid_next = 1'b0;
                        last_next      = 1'b0;
                        done_next      = 1'b1;
                    end else begin
                        index_next = index_inc;
                        seg_next   = snap_seg[index_inc];
                        last_next  = (index_inc == tail_reg);
                    end
                end
            end
            default: ;
        endcase
    end

    assign seg_valid  = seg_valid_reg;
    assign seg_index  = index_reg;
    assign seg_orient = seg_reg[11:8];
    assign seg_y      = seg_reg[7:4];
    assign seg_x      = seg_reg[3:0];
    assign seg_last   = last_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

`ifdef DRAGON_SELF_COLLIDE_EN
    logic             collide_reg;
    logic [IDX_W-1:0] collide_index_reg;

    // Flag transferred body segments that share the snapshot head's tile;
    // remember only the first offending index
    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            collide_reg       <= 1'b0;
            collide_index_reg <= '0;
        end else if (transfer && (index_reg != '0) &&
                     (seg_reg[7:0] == snap_seg[0][7:0])) begin
            collide_reg <= 1'b1;
            if (!collide_reg) collide_index_reg <= index_reg;
        end
    end

    assign collide       = collide_reg;
    assign collide_index = collide_index_reg;
`endif

endmodule

// File: tb/tb_dragon_body_reader.sv
// Directed testbench for dragon_body_reader. Define DRAGON_SELF_COLLIDE_EN
// to also exercise the self-collision outputs.
module tb_dragon_body_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [95:0] dragon_body;
    logic [2:0]  tail_ptr;
    logic        seg_valid;
    logic        seg_ready;
    logic [2:0]  seg_index;
    logic [3:0]  seg_orient;
    logic [3:0]  seg_x;
    logic [3:0]  seg_y;
    logic        seg_last;
    logic        busy;
    logic        done;
`ifdef DRAGON_SELF_COLLIDE_EN
    logic        collide;
    logic [2:0]  collide_index;
`endif

    int vectors    = 0;
    int miscompares = 0;

    dragon_body_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dragon_body (dragon_body),
        .tail_ptr    (tail_ptr),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_index   (seg_index),
        .seg_orient  (seg_orient),
        .seg_x       (seg_x),
        .seg_y       (seg_y),
        .seg_last    (seg_last),
        .busy        (busy),
        .done        (done)
`ifdef DRAGON_SELF_COLLIDE_EN
        ,
        .collide       (collide),
        .collide_index (collide_index)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the done pulse
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_timeout: done=%b required 1 within 20 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; seg_ready = 1'b0; tail_ptr = 3'd0;
        dragon_body = 96'h0;
        dragon_body[11:0] = 12'h321;
        tick();
        tick();
        vectors++;
        if ({seg_valid, seg_index, seg_orient, seg_x, seg_y, seg_last, busy, done} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0",
                     {seg_valid, seg_index, seg_orient, seg_x, seg_y, seg_last, busy, done});
        end
        $display("reset: outputs valid=%b busy=%b done=%b", seg_valid, busy, done);
        reset = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({seg_valid, seg_index, busy, seg_orient, seg_y, seg_x} !== {1'b1, 3'd0, 1'b1, 12'h321}) begin
            miscompares++;
            $display("FAIL reset_first_start: valid=%b idx=%0d busy=%b seg=%h required 1/0/1/321",
                     seg_valid, seg_index, busy, {seg_orient, seg_y, seg_x});
        end
        $display("reset: start after release valid=%b idx=%0d", seg_valid, seg_index);
        seg_ready = 1'b1;
        wait_done("reset");
        tick();
        seg_ready = 1'b0;
    endtask

    task automatic test_single();
        dragon_body = 96'h0;
        dragon_body[11:0] = 12'hA53;
        tail_ptr = 3'd0; start = 1'b1; seg_ready = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last} !== {1'b1, 3'd0, 4'hA, 4'h5, 4'h3, 1'b1}) begin
            miscompares++;
            $display("FAIL single_seg: valid=%b idx=%0d o=%h y=%h x=%h last=%b required 1/0/A/5/3/1",
                     seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last);
        end
        $display("single: idx=%0d o=%h y=%h x=%h last=%b", seg_index, seg_orient, seg_y, seg_x, seg_last);
        tick();
        vectors++;
        if ({done, busy, seg_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL single_done: done=%b busy=%b valid=%b required 1/1/0", done, busy, seg_valid);
        end
        $display("single: done=%b busy=%b", done, busy);
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle: done=%b busy=%b required 0/0", done, busy);
        end
        $display("single: idle done=%b busy=%b", done, busy);
        seg_ready = 1'b0;
    endtask

    task automatic test_full();
        int done_count;
        done_count = 0;
        for (int k = 0; k < 8; k++) dragon_body[k*12 +: 12] = {4'h0, 4'(k), 4'(k)};
        tail_ptr = 3'd7; start = 1'b1; seg_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last, done} !==
                {1'b1, 3'(i), 4'h0, 4'(i), 4'(i), (i == 7), 1'b0}) begin
                miscompares++;
                $display("FAIL full_seg%0d: valid=%b idx=%0d o=%h y=%h x=%h last=%b done=%b",
                         i, seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last, done);
            end
            $display("full: idx=%0d y=%h x=%h last=%b", seg_index, seg_y, seg_x, seg_last);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (done) done_count++;
            tick();
        end
        vectors++;
        if (done_count !== 1) begin
            miscompares++;
            $display("FAIL full_done_count: got %0d required 1", done_count);
        end
        $display("full: done pulses=%0d", done_count);
        seg_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [95:0] orig;
        for (int k = 0; k < 8; k++) orig[k*12 +: 12] = {4'h2, 4'(k), 4'(15 - k)};
        dragon_body = orig; tail_ptr = 3'd3; start = 1'b1; seg_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        seg_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dragon_body = ~orig; tail_ptr = 3'd7; start = 1'b1;
            vectors++;
            if ({seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last} !== {1'b1, 3'd1, 12'h21E, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_stall%0d: valid=%b idx=%0d seg=%h last=%b required 1/1/21E/0",
                         c, seg_valid, seg_index, {seg_orient, seg_y, seg_x}, seg_last);
            end
            $display("bp: stall %0d idx=%0d seg=%h", c, seg_index, {seg_orient, seg_y, seg_x});
            tick();
        end
        start = 1'b0; seg_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if ({seg_valid, seg_index, seg_orient, seg_y, seg_x, seg_last} !==
                {1'b1, 3'(i), orig[i*12 +: 12], (i == 3)}) begin
                miscompares++;
                $display("FAIL bp_seg%0d: valid=%b idx=%0d seg=%h last=%b required seg %h",
                         i, seg_valid, seg_index, {seg_orient, seg_y, seg_x}, seg_last, orig[i*12 +: 12]);
            end
            $display("bp: idx=%0d seg=%h last=%b", seg_index, {seg_orient, seg_y, seg_x}, seg_last);
            tick();
        end
        vectors++;
        if ({done, seg_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_done: done=%b valid=%b required 1/0", done, seg_valid);
        end
        tick();
        vectors++;
        if ({busy, seg_valid, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL bp_no_restart: busy=%b valid=%b done=%b required 0/0/0", busy, seg_valid, done);
        end
        $display("bp: after done busy=%b valid=%b", busy, seg_valid);
        seg_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        for (int k = 0; k < 8; k++) dragon_body[k*12 +: 12] = {4'h5, 4'(k), 4'h9};
        tail_ptr = 3'd7; start = 1'b1; seg_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (seg_index !== 3'd2) begin
            miscompares++;
            $display("FAIL rmid_at2: idx=%0d required 2", seg_index);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if ({seg_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL rmid_cleared: valid=%b busy=%b done=%b required 0/0/0", seg_valid, busy, done);
        end
        $display("rmid: after reset valid=%b busy=%b", seg_valid, busy);
        for (int c = 0; c < 3; c++) begin
            if (done) done_seen++;
            tick();
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL rmid_no_done: got %0d pulses required 0", done_seen);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({seg_valid, seg_index, seg_orient, seg_y, seg_x} !== {1'b1, 3'd0, 12'h509}) begin
            miscompares++;
            $display("FAIL rmid_restart: valid=%b idx=%0d seg=%h required 1/0/509",
                     seg_valid, seg_index, {seg_orient, seg_y, seg_x});
        end
        $display("rmid: restart idx=%0d seg=%h", seg_index, {seg_orient, seg_y, seg_x});
        wait_done("rmid");
        tick();
        seg_ready = 1'b0;
    endtask

`ifdef DRAGON_SELF_COLLIDE_EN
    task automatic test_collide();
        for (int k = 0; k < 8; k++) dragon_body[k*12 +: 12] = {4'h0, 4'(k), 4'h1};
        dragon_body[11:0]  = 12'h064;
        dragon_body[47:36] = 12'h164;
        dragon_body[71:60] = 12'h264;
        tail_ptr = 3'd6; start = 1'b1; seg_ready = 1'b1;
        tick();
        start = 1'b0;
        wait_done("collide");
        vectors++;
        if ({collide, collide_index} !== {1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL collide_hit: collide=%b idx=%0d required 1/3", collide, collide_index);
        end
        $display("collide: collide=%b idx=%0d", collide, collide_index);
        tick();
        dragon_body[47:36] = 12'h131;
        dragon_body[71:60] = 12'h151;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("nocollide");
        vectors++;
        if ({collide, collide_index} !== {1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL collide_clear: collide=%b idx=%0d required 0/0", collide, collide_index);
        end
        $display("collide: second scan collide=%b", collide);
        tick();
        seg_ready = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; seg_ready = 1'b0;
        dragon_body = 96'h0; tail_ptr = 3'd0;
        test_reset();
        test_single();
        test_full();
        test_backpressure();
        test_reset_mid();
`ifdef DRAGON_SELF_COLLIDE_EN
        test_collide();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
